// File: rtl/pattern_loader_pkg.sv
// Shared sizing, counter widths and FSM encoding for the pattern buffer loader.
package pattern_loader_pkg;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BUFFER_WIDTH = 8;
    localparam int unsigned BUFFER_SIZE  = 32;
    localparam int unsigned BIT_CNT_W    = cnt_w(BUFFER_WIDTH);
    // Byte counters must reach BUFFER_SIZE itself, hence the +1.
    localparam int unsigned BYTE_CNT_W   = cnt_w(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pattern_loader_if.sv
// Control, byte stream, serial buffer link and status of the pattern loader.
interface pattern_loader_if #(
    parameter int unsigned width = 8
);
    logic             start;
    logic             abort;
    logic [width-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sin;
    logic             ssel;
    logic [width-1:0] rb_data;
    logic             rb_valid;
    logic             busy;
    logic             done;
    logic [width-1:0] checksum;

    modport master (
        output start, abort, in_data, in_valid, sout,
        input  in_ready, sin, ssel, rb_data, rb_valid, busy, done, checksum
    );

    modport slave (
        input  start, abort, in_data, in_valid, sout,
        output in_ready, sin, ssel, rb_data, rb_valid, busy, done, checksum
    );
endinterface

// File: rtl/pattern_ser.sv
// Byte serializer/deserializer: shifts a byte out MSB first while capturing the
// returning serial stream, and flags the last bit of each byte.
module pattern_ser
    import pattern_loader_pkg::*;
#(
    parameter int unsigned width = BUFFER_WIDTH,
    parameter int unsigned bit_w = BIT_CNT_W
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [width-1:0] load_data,
    input  logic             sout,
    output logic             sin,
    output logic             last,
    output logic [width-1:0] rx_word
);
    localparam logic [bit_w-1:0] LastBit = bit_w'(width - 1);

    logic [width-1:0] tx_q, tx_d;
    logic [width-2:0] rx_q, rx_d;
    logic [bit_w-1:0] bit_q, bit_d;

    assign sin     = tx_q[width-1];
    assign rx_word = {rx_q, sout};
    assign last    = shift && (bit_q == LastBit);

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        bit_d = bit_q;
        if (shift) begin
            tx_d  = {tx_q[width-2:0], 1'b0};
            rx_d  = rx_word[width-2:0];
            bit_d = (bit_q == LastBit) ? '0 : bit_q + bit_w'(1);
        end
        // A reload at the last bit overrides the shift so the next byte follows seamlessly.
        if (load) tx_d = load_data;
        if (clr) begin
            tx_d  = '0;
            bit_d = '0;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            bit_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/pattern_loader.sv
// Frame loader: accepts buffer_size bytes through a one-entry holding register and
// streams them into the serial pattern buffer, reading back the displaced contents.
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int unsigned buffer_width = BUFFER_WIDTH,
    parameter int unsigned buffer_size  = BUFFER_SIZE
) (
    input  logic            sclk,
    input  logic            rst,
    pattern_loader_if.slave bus
);
    localparam int unsigned ByteW = (buffer_size == BUFFER_SIZE) ? BYTE_CNT_W
                                                                  : cnt_w(buffer_size + 1);
    localparam logic [ByteW-1:0] SizeCnt  = ByteW'(buffer_size);
    localparam logic [ByteW-1:0] LastByte = ByteW'(buffer_size - 1);

    state_e                  state_q, state_d;
    logic [buffer_width-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [ByteW-1:0]        acc_cnt_q, acc_cnt_d;
    logic [ByteW-1:0]        sh_cnt_q, sh_cnt_d;
    logic                    ssel_q, ssel_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rb_valid_q, rb_valid_d;
    logic [buffer_width-1:0] rb_data_q, rb_data_d;
    logic [buffer_width-1:0] checksum_q, checksum_d;

    logic                    in_frame, in_ready, take;
    logic                    start_go, abort_go;
    logic                    ser_load, ser_clr, ser_sin, ser_last, byte_end;
    logic [buffer_width-1:0] ser_word;

    assign in_frame = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
    assign in_ready = in_frame && !hold_full_q && (acc_cnt_q != SizeCnt);
    assign take     = bus.in_valid && in_ready;
    // abort has priority over a simultaneous start while idle.
    assign start_go = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign abort_go = in_frame && bus.abort;
    assign byte_end = ser_last && (sh_cnt_q == LastByte);
    assign ser_clr  = start_go || abort_go;
    assign ser_load = !abort_go && hold_full_q &&
                      ((state_q == ST_WAIT) || ((state_q == ST_SHIFT) && ser_last && !byte_end));

    pattern_ser #(
        .width (buffer_width),
        .bit_w (cnt_w(buffer_width))
    ) u_ser (
        .sclk      (sclk),
        .rst       (rst),
        .clr       (ser_clr),
        .load      (ser_load),
        .shift     (ssel_q),
        .load_data (hold_q),
        .sout      (bus.sout),
        .sin       (ser_sin),
        .last      (ser_last),
        .rx_word   (ser_word)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            acc_cnt_q   <= '0;
            sh_cnt_q    <= '0;
            ssel_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rb_valid_q  <= 1'b0;
            rb_data_q   <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            acc_cnt_q   <= acc_cnt_d;
            sh_cnt_q    <= sh_cnt_d;
            ssel_q      <= ssel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rb_valid_q  <= rb_valid_d;
            rb_data_q   <= rb_data_d;
            checksum_q  <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.abort)        state_d = ST_IDLE;
                else if (hold_full_q) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.abort)     state_d = ST_IDLE;
                else if (byte_end) state_d = ST_DONE;
                else if (ser_last) state_d = hold_full_q ? ST_SHIFT : ST_WAIT;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        acc_cnt_d   = acc_cnt_q;
        sh_cnt_d    = sh_cnt_q;
        rb_data_d   = rb_data_q;
        checksum_d  = checksum_q;
        rb_valid_d  = ser_last;
        ssel_d      = (state_d == ST_SHIFT);
        busy_d      = (state_d == ST_WAIT) || (state_d == ST_SHIFT);
        done_d      = (state_d == ST_DONE);
        if (take) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + ByteW'(1);
        end
        if (ser_load) hold_full_d = 1'b0;
        if (ser_last) begin
            rb_data_d  = ser_word;
            checksum_d = checksum_q + ser_word;
            sh_cnt_d   = sh_cnt_q + ByteW'(1);
        end
        if (start_go) begin
            acc_cnt_d   = '0;
            sh_cnt_d    = '0;
            checksum_d  = '0;
            hold_full_d = 1'b0;
        end
        if (abort_go) hold_full_d = 1'b0;
    end

    assign bus.in_ready = in_ready;
    assign bus.sin      = ser_sin;
    assign bus.ssel     = ssel_q;
    assign bus.rb_data  = rb_data_q;
    assign bus.rb_valid = rb_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.checksum = checksum_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: models the serial pattern buffer and scoreboards readback.
module tb_pattern_loader;
    localparam int W  = 8;
    localparam int N  = 32;
    localparam int NB = W * N;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    pattern_loader_if #(.width(W)) bus ();

    pattern_loader #(.buffer_width(W), .buffer_size(N)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    // Pattern buffer model: one long shift register, top bit returned on sout.
    logic [NB-1:0] pbuf    = '0;
    logic [NB-1:0] pre_val = '0;
    logic          pre_en  = 1'b0;
    always @(posedge sclk) begin
        if (pre_en)        pbuf <= pre_val;
        else if (bus.ssel) pbuf <= {pbuf[NB-2:0], bus.sin};
    end
    assign bus.sout = pbuf[NB-1];

    int n_checks = 0;
    int n_pass   = 0;
    int ssel_total = 0;
    int ssel_fall  = 0;
    int done_total = 0;
    logic ssel_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [7:0] pat(input int k);
        return pbuf[k*W +: W];
    endfunction

    always @(negedge sclk) begin
        logic [7:0] e;
        if (bus.ssel === 1'b1) ssel_total++;
        if (ssel_prev && bus.ssel === 1'b0) ssel_fall++;
        ssel_prev = (bus.ssel === 1'b1);
        if (bus.done === 1'b1) done_total++;
        if (bus.rb_valid === 1'b1) begin
            check("rb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rb_data", bus.rb_data, e);
            end
        end
    end

    task automatic run_frame(input logic [7:0] base, input int gap_after, input int gap_len,
                             input int stop_at, input bit use_rst);
        logic [7:0] bytes [N];
        logic [7:0] sum;
        logic [7:0] v;
        int sent, shifts, gap, n_rb, d0, s0, f0, nbad, falls;
        bit acc, s, finished, stopped;
        sum = '0; sent = 0; shifts = 0; gap = 0; nbad = 0;
        finished = 0; stopped = 0;
        for (int k = 0; k < N; k++) bytes[k] = base + 8'(k);
        n_rb = (stop_at < 0) ? N : stop_at / W;
        for (int j = 0; j < n_rb; j++) begin
            v = pat(N - 1 - j);
            exp_q.push_back(v);
            sum += v;
        end
        d0 = done_total; s0 = ssel_total; f0 = ssel_fall;
        bus.start = 1'b1;
        @(posedge sclk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished && !stopped; cyc++) begin
            bus.in_valid = (sent < N) && (gap == 0);
            bus.in_data  = bytes[(sent < N) ? sent : 0];
            if (stop_at >= 0 && bus.ssel === 1'b1 && shifts == stop_at) begin
                stopped = 1;
                if (use_rst) rst = 1'b1;
                else bus.abort = 1'b1;
            end
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            s   = (bus.ssel === 1'b1);
            @(posedge sclk); #1;
            if (s) shifts++;
            if (acc) begin
                sent++;
                if (sent == gap_after + 1) gap = gap_len;
            end else if (gap > 0) gap--;
            if (bus.done === 1'b1) finished = 1;
        end
        rst = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        if (stop_at >= 0) begin
            check("stop_ssel", bus.ssel, 0);
            check("stop_busy", bus.busy, 0);
            check("stop_ready", bus.in_ready, 0);
            check("stop_done", bus.done, 0);
            if (use_rst) begin
                check("rst_sin", bus.sin, 0);
                check("rst_rb_data", bus.rb_data, 0);
                check("rst_rb_valid", bus.rb_valid, 0);
                check("rst_checksum", bus.checksum, 0);
            end
        end else begin
            check("done_seen", finished, 1);
            check("checksum", bus.checksum, sum);
            check("done_busy", bus.busy, 0);
            check("done_ssel", bus.ssel, 0);
        end
        repeat (2) @(posedge sclk);
        #1;
        check("done_pulses", done_total - d0, (stop_at < 0) ? 1 : 0);
        check("rb_drain", exp_q.size(), 0);
        if (stop_at < 0) begin
            falls = ssel_fall - f0;
            check("ssel_cycles", ssel_total - s0, NB);
            check("ssel_runs", falls, (gap_len > 16) ? 2 : 1);
            for (int k = 0; k < N; k++) if (pat(k) !== bytes[N - 1 - k]) nbad++;
            check("pat_top", pat(N - 1), bytes[0]);
            check("pat_bot", pat(0), bytes[N - 1]);
            check("pat_bad_count", nbad, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge sclk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ssel", bus.ssel, 0);
        check("rst_sin", bus.sin, 0);
        check("rst_done", bus.done, 0);
        check("rst_rb_valid", bus.rb_valid, 0);
        check("rst_rb_data", bus.rb_data, 0);
        check("rst_checksum", bus.checksum, 0);
        rst = 1'b0;
        @(posedge sclk); #1;

        // start together with abort, and stray in_valid, while idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5A;
        @(posedge sclk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_busy", bus.busy, 0);
            check("idle_in_ready", bus.in_ready, 0);
            check("idle_ssel", bus.ssel, 0);
            @(posedge sclk); #1;
        end
        bus.in_valid = 1'b0;

        run_frame(8'h00, -2, 0, -1, 1'b0);

        for (int k = 0; k < N; k++) pre_val[k*W +: W] = 8'(k);
        pre_en = 1'b1;
        @(posedge sclk); #1;
        pre_en = 1'b0;
        run_frame(8'hA0, -2, 0, -1, 1'b0);
        check("checksum_f0", bus.checksum, 8'hF0);

        run_frame(8'h40, 3, 5, -1, 1'b0);
        run_frame(8'h50, 3, 20, -1, 1'b0);

        run_frame(8'h60, -2, 0, 10 * W + 4, 1'b0);
        run_frame(8'h80, -2, 0, -1, 1'b0);

        run_frame(8'h20, -2, 0, 2 * W + 4, 1'b1);
        run_frame(8'h10, -2, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
